st_sample_pacer: RTL and testbench
==================================

Name: st_sample_pacer

Overview:
- Downstream consumer of the 16-bit Avalon-ST sample stream produced by the MM-to-ST data adapter.
- Buffers incoming samples in a small FIFO and releases exactly one sample every (rate_div+1) clocks to the DAC/reconstruction output path.
- The output rate is therefore fixed and independent of upstream burstiness; FIFO underruns are detected and counted.

Parameters:
- DATA_WIDTH, 16, sample width; must match the upstream stream data width.
- FIFO_DEPTH, 16, number of FIFO entries; power of two, ≥4.
- DIV_WIDTH, 16, width of the rate divider input.
- CNT_WIDTH, 16, width of the underrun counter.

Ports:
- avalon_st_clk  in  1  single clock for all logic.
- avalon_st_reset  in  1  asynchronous, active-high reset.
- avalon_st_sink_data  in  DATA_WIDTH  sample from the upstream stream.
- avalon_st_sink_valid  in  1  sample valid.
- avalon_st_sink_ready  out  1  block can accept a sample.
- enable  in  1  pacer run request; level-sensitive.
- rate_div  in  DIV_WIDTH  output period minus one, in clocks.
- sample_out  out  DATA_WIDTH  current output sample; registered and held between strobes.
- sample_strobe  out  1  one-cycle pulse when sample_out updates.
- running  out  1  high while in RUN.
- fill_level  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.
- underrun_count  out  CNT_WIDTH  saturating count of underruns.

Behaviour:
- Interface (decided):
  - One clock, avalon_st_clk.
  - avalon_st_reset is asynchronous and active-high.
  - All state clears immediately on assertion of avalon_st_reset and is released synchronously.
- Reset values:
  - sample_out=0, sample_strobe=0, running=0, fill_level=0, underrun_count=0.
  - FIFO empty; state=IDLE; divider counter=0.
  - avalon_st_sink_ready=1 once reset is deasserted.
- Sink handshake:
  - avalon_st_sink_ready = !full. It is combinational from registered occupancy and does not depend on a same-cycle pop.
  - A push occurs when valid && ready at a rising edge.
  - fill_level reflects the push in the following cycle.
  - The FIFO accepts samples in all states, including IDLE, so data can be pre-loaded.
- Simultaneous push and pop (FIFO not full): occupancy is unchanged; data order is preserved.
- Pointers wrap modulo FIFO_DEPTH.
- States:
  - IDLE: counter held at 0; no strobes. enable=1 → PRIME.
  - PRIME: waits until fill_level ≥ FIFO_DEPTH/2, then → RUN with counter=0. enable=0 → IDLE.
  - RUN:
    - running=1.
    - The counter increments each clock. When counter==rate_div at a clock edge, the counter resets to 0 and a tick occurs.
    - On a tick with the FIFO non-empty: pop the head into sample_out and pulse sample_strobe for 1 cycle.
    - On a tick with the FIFO empty (underrun): sample_out holds its value, sample_strobe still pulses, underrun_count increments (saturates at all-ones), state → PRIME.
    - enable=0 → IDLE at the next edge with no tick in that cycle; sample_out holds.
- Timing:
  - The first tick occurs rate_div+1 clocks after entering RUN.
  - The strobe period is exactly rate_div+1 clocks.
  - rate_div=0 gives a strobe every clock.
- rate_div is sampled live.
  - If it changes so that the counter is already > rate_div, the counter still rolls to 0 on the next clock and a tick occurs.
  - No hang is permitted.
- Output is independent of upstream packet delimiters; sop/eop/empty are not consumed.
- Reset mid-operation: the FIFO is flushed; outputs return to reset values within the same cycle as assertion (asynchronous).

Test Plan:
- Reset/idle:
  - Assert reset mid-RUN with fill_level=5 → all outputs 0 immediately, sink_ready=1 after release.
  - Push 3 samples in IDLE → fill_level=3, no strobes.
- Prime and pace:
  - DEPTH=16, rate_div=3, push 0x0001..0x0010, enable=1 → RUN once fill_level≥8.
  - Strobes every 4 clocks with values 0x0001, 0x0002, … in order; first strobe 4 clocks after running rises.
- Backpressure:
  - enable=0, push 20 samples continuously → sink_ready falls after the 16th accept; fill_level=16; samples 17–20 held off.
  - Draining one entry → ready=1 the next cycle.
- Underrun:
  - rate_div=1, load 8 samples, run, stop pushing → 8 strobes with data.
  - The 9th strobe repeats the last value; underrun_count=1; running=0 (PRIME).
- Rate extremes:
  - rate_div=0 with FIFO kept fed → sample_strobe high every cycle, no underrun.
  - Drop rate_div from 100 to 2 while counter=50 → tick on the next clock, then a period of 3.
- Enable drop:
  - Deassert enable in RUN → running=0 on the next edge; no further strobes; sample_out holds; FIFO contents retained.

Source files
------------

// File: rtl/st_sample_pacer.sv
// Sample pacer: buffers an Avalon-ST sample stream in a small FIFO and releases
// one sample every (rate_div+1) clocks, counting underruns.
module st_sample_pacer #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          avalon_st_clk,
    input  logic                          avalon_st_reset,
    input  logic [DATA_WIDTH-1:0]         avalon_st_sink_data,
    input  logic                          avalon_st_sink_valid,
    output logic                          avalon_st_sink_ready,
    input  logic                          enable,
    input  logic [DIV_WIDTH-1:0]          rate_div,
    output logic [DATA_WIDTH-1:0]         sample_out,
    output logic                          sample_strobe,
    output logic                          running,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic [CNT_WIDTH-1:0]          underrun_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] HALF_LVL = LVL_W'(FIFO_DEPTH / 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [DATA_WIDTH-1:0]  mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [LVL_W-1:0]       level_r;
    logic [DIV_WIDTH-1:0]   div_cnt_r;
    logic [DIV_WIDTH-1:0]   div_cnt_s;
    logic [DATA_WIDTH-1:0]  sample_r;
    logic                   strobe_r;
    logic                   running_r;
    logic [CNT_WIDTH-1:0]   underrun_r;

    logic full_s;
    logic empty_s;
    logic push_s;
    logic tick_s;
    logic pop_s;
    logic underrun_s;

    assign full_s     = (level_r == FULL_LVL);
    assign empty_s    = (level_r == {LVL_W{1'b0}});
    assign push_s     = avalon_st_sink_valid && !full_s;
    // ">=" rather than "==" so a live drop of rate_div below the counter still ticks
    assign tick_s     = (state_r == ST_RUN) && enable && (div_cnt_r >= rate_div);
    assign pop_s      = tick_s && !empty_s;
    assign underrun_s = tick_s && empty_s;

    assign avalon_st_sink_ready = !full_s;
    assign fill_level           = level_r;
    assign sample_out           = sample_r;
    assign sample_strobe        = strobe_r;
    assign running              = running_r;
    assign underrun_count       = underrun_r;

    // State register
    always_ff @(posedge avalon_st_clk or posedge avalon_st_reset) begin
        if (avalon_st_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) state_s = ST_PRIME;
                else        state_s = ST_IDLE;
            end
            ST_PRIME: begin
                if (!enable)                state_s = ST_IDLE;
                else if (level_r >= HALF_LVL) state_s = ST_RUN;
                else                        state_s = ST_PRIME;
            end
            ST_RUN: begin
                if (!enable)         state_s = ST_IDLE;
                else if (underrun_s) state_s = ST_PRIME;
                else                 state_s = ST_RUN;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Divider next value: counts only while staying in RUN, otherwise parked at zero
    always_comb begin
        div_cnt_s = div_cnt_r;
        if ((state_r == ST_RUN) && (state_s == ST_RUN)) begin
            if (tick_s) div_cnt_s = {DIV_WIDTH{1'b0}};
            else        div_cnt_s = div_cnt_r + 1'b1;
        end else begin
            div_cnt_s = {DIV_WIDTH{1'b0}};
        end
    end

    // Registered outputs and divider counter
    always_ff @(posedge avalon_st_clk or posedge avalon_st_reset) begin
        if (avalon_st_reset) begin
            div_cnt_r  <= {DIV_WIDTH{1'b0}};
            sample_r   <= {DATA_WIDTH{1'b0}};
            strobe_r   <= 1'b0;
            running_r  <= 1'b0;
            underrun_r <= {CNT_WIDTH{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_s;
            strobe_r  <= tick_s;
            running_r <= (state_s == ST_RUN);
            if (pop_s) begin
                sample_r <= mem_r[rd_ptr_r];
            end
            if (underrun_s && (underrun_r != {CNT_WIDTH{1'b1}})) begin
                underrun_r <= underrun_r + 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge avalon_st_clk or posedge avalon_st_reset) begin
        if (avalon_st_reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + 1'b1;
                2'b01:   level_r <= level_r - 1'b1;
                default: level_r <= level_r;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge avalon_st_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= avalon_st_sink_data;
        end
    end

endmodule

// File: tb/tb_st_sample_pacer.sv
// Directed bench for st_sample_pacer: reset, pre-load, backpressure, pacing,
// enable drop, underrun, rate extremes and live rate change.
module tb_st_sample_pacer;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic [15:0] data     = 16'h0000;
    logic        valid    = 1'b0;
    logic        ready;
    logic        enable   = 1'b0;
    logic [15:0] rate_div = 16'd0;
    logic [15:0] sample_out;
    logic        strobe;
    logic        running;
    logic [4:0]  fill;
    logic [15:0] underrun;

    int n_checks   = 0;
    int n_errors   = 0;
    int strobe_cnt = 0;
    int base       = 0;

    st_sample_pacer #(
        .DATA_WIDTH(16),
        .FIFO_DEPTH(16),
        .DIV_WIDTH (16),
        .CNT_WIDTH (16)
    ) dut (
        .avalon_st_clk       (clk),
        .avalon_st_reset     (rst),
        .avalon_st_sink_data (data),
        .avalon_st_sink_valid(valid),
        .avalon_st_sink_ready(ready),
        .enable              (enable),
        .rate_div            (rate_div),
        .sample_out          (sample_out),
        .sample_strobe       (strobe),
        .running             (running),
        .fill_level          (fill),
        .underrun_count      (underrun)
    );

    always #5 clk = ~clk;

    // Count strobe pulses as seen at the active edge
    always @(posedge clk) begin
        if (strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_sample", 32'(sample_out), 32'h0);
        chk("rst_strobe", 32'(strobe), 32'h0);
        chk("rst_running", 32'(running), 32'h0);
        chk("rst_fill", 32'(fill), 32'h0);
        chk("rst_underrun", 32'(underrun), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'h1);

        // Pre-load three samples while IDLE
        for (int i = 0; i < 3; i++) begin
            data  = 16'(16'h00A1 + i);
            valid = 1'b1;
            @(negedge clk);
        end
        valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_fill", 32'(fill), 32'd3);
        chk("idle_no_strobe", 32'(strobe_cnt), 32'd0);
        chk("idle_running", 32'(running), 32'h0);

        // Flush with reset
        rst = 1'b1;
        @(negedge clk);
        chk("flush_fill", 32'(fill), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Backpressure: 16 accepts, then ready drops and further samples wait
        for (int i = 1; i <= 16; i++) begin
            chk("bp_ready_hi", 32'(ready), 32'h1);
            data  = 16'(i);
            valid = 1'b1;
            @(negedge clk);
        end
        chk("bp_ready_lo", 32'(ready), 32'h0);
        chk("bp_fill_full", 32'(fill), 32'd16);
        data = 16'd17;
        repeat (3) @(negedge clk);
        chk("bp_held_fill", 32'(fill), 32'd16);
        chk("bp_held_ready", 32'(ready), 32'h0);
        valid = 1'b0;

        // Prime and pace at rate_div=3
        enable   = 1'b1;
        rate_div = 16'd3;
        @(negedge clk);
        chk("prime_running_lo", 32'(running), 32'h0);
        @(negedge clk);
        chk("run_running_hi", 32'(running), 32'h1);
        chk("run_no_strobe_yet", 32'(strobe), 32'h0);
        for (int k = 1; k <= 6; k++) begin
            for (int j = 1; j <= 4; j++) begin
                @(negedge clk);
                if (j < 4) begin
                    chk("pace_gap", 32'(strobe), 32'h0);
                    chk("pace_hold", 32'(sample_out), 32'(k - 1));
                end else begin
                    chk("pace_strobe", 32'(strobe), 32'h1);
                    chk("pace_data", 32'(sample_out), 32'(k));
                end
            end
            if (k == 1) begin
                chk("drain_ready", 32'(ready), 32'h1);
                chk("drain_fill", 32'(fill), 32'd15);
            end
        end

        // Enable drop: leave RUN at once, hold sample, keep FIFO
        enable = 1'b0;
        @(negedge clk);
        chk("drop_running", 32'(running), 32'h0);
        chk("drop_strobe", 32'(strobe), 32'h0);
        base = strobe_cnt;
        repeat (8) @(negedge clk);
        chk("drop_no_strobes", 32'(strobe_cnt), 32'(base));
        chk("drop_sample_hold", 32'(sample_out), 32'd6);
        chk("drop_fill_kept", 32'(fill), 32'd10);

        // rate_div=0 drain down to 5 entries, then reset mid-RUN
        enable   = 1'b1;
        rate_div = 16'd0;
        @(negedge clk);
        @(negedge clk);
        chk("r0_running", 32'(running), 32'h1);
        for (int k = 7; k <= 11; k++) begin
            @(negedge clk);
            chk("r0_strobe", 32'(strobe), 32'h1);
            chk("r0_data", 32'(sample_out), 32'(k));
        end
        chk("r0_fill5", 32'(fill), 32'd5);
        rst = 1'b1;
        #1;
        chk("async_sample", 32'(sample_out), 32'h0);
        chk("async_strobe", 32'(strobe), 32'h0);
        chk("async_running", 32'(running), 32'h0);
        chk("async_fill", 32'(fill), 32'h0);
        chk("async_underrun", 32'(underrun), 32'h0);
        @(negedge clk);
        rst    = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk("rel_ready", 32'(ready), 32'h1);
        chk("rel_fill", 32'(fill), 32'h0);

        // Underrun at rate_div=1 with 8 samples loaded
        rate_div = 16'd1;
        for (int i = 1; i <= 8; i++) begin
            data  = 16'(16'h0100 + i);
            valid = 1'b1;
            @(negedge clk);
        end
        valid  = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ur_running", 32'(running), 32'h1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("ur_gap", 32'(strobe), 32'h0);
            @(negedge clk);
            chk("ur_strobe", 32'(strobe), 32'h1);
            chk("ur_data", 32'(sample_out), (k <= 8) ? 32'(16'h0100 + k) : 32'h0108);
            chk("ur_count", 32'(underrun), (k <= 8) ? 32'd0 : 32'd1);
            chk("ur_run_state", 32'(running), (k <= 8) ? 32'h1 : 32'h0);
        end

        // rate_div=0 with a continuously fed FIFO
        rate_div = 16'd0;
        data     = 16'h0200;
        valid    = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (i >= 9)  chk("fed_running", 32'(running), 32'h1);
            if (i >= 10) begin
                chk("fed_strobe", 32'(strobe), 32'h1);
                chk("fed_data", 32'(sample_out), 32'(16'h0200 + i - 10));
                chk("fed_fill", 32'(fill), 32'd9);
            end
            data = 16'(16'h0200 + i);
        end
        chk("fed_no_underrun", 32'(underrun), 32'd1);
        enable = 1'b0;
        valid  = 1'b0;
        @(negedge clk);
        chk("fed_stop", 32'(running), 32'h0);

        // Live rate change: 100 -> 2 while counter is 50
        enable   = 1'b1;
        rate_div = 16'd100;
        @(negedge clk);
        @(negedge clk);
        chk("rc_running", 32'(running), 32'h1);
        base = strobe_cnt;
        repeat (50) @(negedge clk);
        chk("rc_quiet", 32'(strobe_cnt), 32'(base));
        chk("rc_quiet_now", 32'(strobe), 32'h0);
        rate_div = 16'd2;
        @(negedge clk);
        chk("rc_tick", 32'(strobe), 32'h1);
        chk("rc_tick_data", 32'(sample_out), 32'h020F);
        for (int k = 1; k <= 2; k++) begin
            repeat (2) begin
                @(negedge clk);
                chk("rc_gap", 32'(strobe), 32'h0);
            end
            @(negedge clk);
            chk("rc_period", 32'(strobe), 32'h1);
            chk("rc_data", 32'(sample_out), 32'(16'h020F + k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
